// File: rtl/player_pkg.sv
// player_pkg
// Shared definitions for the per-player action FSM and its consumers:
//   - player_state_e : 3-bit state encoding, exposed on the FSM's state port
//   - DIR_*          : move_dir codes
//   - DEF_*_FRAMES   : default frame lengths, shared with the block controller
//   - player_out_t   : bundle of the FSM's registered outputs
//   - stun_len()     : stun load rule (a zero stun length still lasts one frame)
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE      = 3'd1,
    ST_JUMP      = 3'd2,
    ST_STARTUP   = 3'd3,
    ST_ACTIVE    = 3'd4,
    ST_RECOVERY  = 3'd5,
    ST_HITSTUN   = 3'd6,
    ST_BLOCKSTUN = 3'd7
  } player_state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam int unsigned DEF_STARTUP_FRAMES  = 4;
  localparam int unsigned DEF_ACTIVE_FRAMES   = 3;
  localparam int unsigned DEF_RECOVERY_FRAMES = 8;
  localparam int unsigned DEF_JUMP_FRAMES     = 24;
  localparam int unsigned DEF_BUFFER_FRAMES   = 4;

  typedef struct packed {
    logic       atk_active;
    logic       move_active;
    logic       atk_start_pulse;
    logic       move_start_pulse;
    logic       returned_to_neutral;
    logic       hitstun;
    logic       blockstun;
    logic       hitbox_active;
    logic [1:0] move_dir;
  } player_out_t;

  function automatic logic [7:0] stun_len(input logic [7:0] frames);
    return (frames == 8'd0) ? 8'd1 : frames;
  endfunction

endpackage

// File: rtl/player_frame_counter.sv
// player_frame_counter
// 8-bit loadable down-counter shared by all timed states. Saturates at 0.
// Ports:
//   clk, rst      : frame clock, synchronous active-low reset
//   load          : load load_val this cycle (takes precedence over counting)
//   load_val[7:0] : value loaded on state entry
//   last          : count == 1, i.e. this is the final frame of the state
module player_frame_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       last
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 8'd1);

endmodule

// File: rtl/player_action_fsm.sv
// player_action_fsm
// Per-player action state machine: turns buttons and collision results into
// the activity levels, pulses and stun flags consumed by the auto-block
// controller, and drives this player's own hitbox enable.
// One clk cycle is one game frame.
// Ports:
//   clk, rst                : frame clock, synchronous active-low reset
//   btn_left/right/jump/atk : debounced level buttons
//   hit_taken, hit_blocked  : 1-cycle hit pulses (taken wins over blocked)
//   stun_frames[7:0]        : stun length, sampled with the hit pulse
//   atk_active, move_active : activity levels
//   atk_start_pulse, move_start_pulse, returned_to_neutral : entry pulses
//   hitstun, blockstun      : stun levels
//   hitbox_active           : own hitbox enable (ACTIVE only)
//   move_dir[1:0]           : 01 right, 10 left, 00 none
//   state[2:0]              : current state (player_state_e encoding)
// Optional feature: define PLAYER_ACTION_BUFFER_EN to buffer attack edges
// seen in RECOVERY, HITSTUN, BLOCKSTUN or JUMP for BUFFER_FRAMES frames.
module player_action_fsm
  import player_pkg::*;
#(
  parameter int unsigned STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
  parameter int unsigned ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
  parameter int unsigned RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
  parameter int unsigned JUMP_FRAMES     = DEF_JUMP_FRAMES
`ifdef PLAYER_ACTION_BUFFER_EN
  , parameter int unsigned BUFFER_FRAMES = DEF_BUFFER_FRAMES
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_atk,
  input  logic       hit_taken,
  input  logic       hit_blocked,
  input  logic [7:0] stun_frames,
  output logic       atk_active,
  output logic       move_active,
  output logic       atk_start_pulse,
  output logic       move_start_pulse,
  output logic       returned_to_neutral,
  output logic       hitstun,
  output logic       blockstun,
  output logic       hitbox_active,
  output logic [1:0] move_dir,
  output logic [2:0] state
);

  localparam logic [7:0] STARTUP_LEN  = 8'(STARTUP_FRAMES);
  localparam logic [7:0] ACTIVE_LEN   = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] RECOVERY_LEN = 8'(RECOVERY_FRAMES);
  localparam logic [7:0] JUMP_LEN     = 8'(JUMP_FRAMES);

  player_state_e state_q, state_d;
  player_out_t   out_q, out_d;
  logic          atk_prev_q, atk_prev_d;
  logic          jump_prev_q, jump_prev_d;
  logic          atk_edge, jump_edge;
  logic [1:0]    dir;
  logic          cnt_load;
  logic [7:0]    cnt_val;
  logic          cnt_last;

  assign atk_prev_d  = btn_atk;
  assign jump_prev_d = btn_jump;
  assign atk_edge    = btn_atk & ~atk_prev_q;
  assign jump_edge   = btn_jump & ~jump_prev_q;

  // Both directions held cancel out to no movement.
  assign dir = (btn_right & ~btn_left) ? DIR_RIGHT :
               (btn_left & ~btn_right) ? DIR_LEFT  : DIR_NONE;

`ifdef PLAYER_ACTION_BUFFER_EN
  localparam logic [7:0] BUFFER_LEN = 8'(BUFFER_FRAMES);
  logic       buf_valid_q, buf_valid_d;
  logic [7:0] buf_age_q, buf_age_d;
  logic       buf_capture, buf_pending, buf_take;

  assign buf_capture = atk_edge &&
    (state_q inside {ST_RECOVERY, ST_HITSTUN, ST_BLOCKSTUN, ST_JUMP});
  // An edge captured on the very frame the state ends still counts.
  assign buf_pending = buf_valid_q | buf_capture;
`endif

  // Next-state logic. Hits pre-empt everything and always reload the counter,
  // so a hit during stun restarts it with the new stun type.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
`ifdef PLAYER_ACTION_BUFFER_EN
    buf_take = 1'b0;
`endif
    if (hit_taken) begin
      state_d  = ST_HITSTUN;
      cnt_load = 1'b1;
      cnt_val  = stun_len(stun_frames);
    end else if (hit_blocked) begin
      state_d  = ST_BLOCKSTUN;
      cnt_load = 1'b1;
      cnt_val  = stun_len(stun_frames);
    end else begin
      unique case (state_q)
        ST_IDLE, ST_MOVE: begin
          if (atk_edge)              state_d = ST_STARTUP;
          else if (jump_edge)        state_d = ST_JUMP;
          else if (dir != DIR_NONE)  state_d = ST_MOVE;
          else                       state_d = ST_IDLE;
        end
        ST_STARTUP:  if (cnt_last) state_d = ST_ACTIVE;
        ST_ACTIVE:   if (cnt_last) state_d = ST_RECOVERY;
        ST_RECOVERY, ST_JUMP, ST_HITSTUN, ST_BLOCKSTUN: begin
          if (cnt_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
`ifdef PLAYER_ACTION_BUFFER_EN
      // A pending buffered attack turns the return to IDLE into a new attack.
      if (state_d == ST_IDLE && state_q != ST_IDLE && buf_pending) begin
        state_d  = ST_STARTUP;
        buf_take = 1'b1;
      end
`endif
      if (state_d != state_q) begin
        cnt_load = 1'b1;
        unique case (state_d)
          ST_STARTUP:  cnt_val = STARTUP_LEN;
          ST_ACTIVE:   cnt_val = ACTIVE_LEN;
          ST_RECOVERY: cnt_val = RECOVERY_LEN;
          ST_JUMP:     cnt_val = JUMP_LEN;
          default:     cnt_val = 8'd0;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q; the entry flag marks the first frame of a new state.
  always_comb begin
    logic entry;
    entry = (state_d != state_q);
    out_d = '0;
    out_d.atk_active          = state_d inside {ST_STARTUP, ST_ACTIVE, ST_RECOVERY};
    out_d.move_active         = state_d inside {ST_MOVE, ST_JUMP};
    out_d.atk_start_pulse     = entry && (state_d == ST_STARTUP);
    out_d.move_start_pulse    = entry && (state_d inside {ST_MOVE, ST_JUMP});
    out_d.returned_to_neutral = entry && (state_d == ST_IDLE);
    out_d.hitstun             = (state_d == ST_HITSTUN);
    out_d.blockstun           = (state_d == ST_BLOCKSTUN);
    out_d.hitbox_active       = (state_d == ST_ACTIVE);
    out_d.move_dir            = (state_d == ST_MOVE) ? dir : DIR_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      atk_prev_q  <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      atk_prev_q  <= atk_prev_d;
      jump_prev_q <= jump_prev_d;
    end
  end

`ifdef PLAYER_ACTION_BUFFER_EN
  // Buffer age counts down every frame; reaching zero drops the attack.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_age_d   = buf_age_q;
    if (buf_take) begin
      buf_valid_d = 1'b0;
      buf_age_d   = 8'd0;
    end else if (buf_capture) begin
      buf_valid_d = 1'b1;
      buf_age_d   = BUFFER_LEN;
    end else if (buf_valid_q) begin
      if (buf_age_q <= 8'd1) begin
        buf_valid_d = 1'b0;
        buf_age_d   = 8'd0;
      end else begin
        buf_age_d = buf_age_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_age_q   <= 8'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_age_q   <= buf_age_d;
    end
  end
`endif

  player_frame_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  assign atk_active          = out_q.atk_active;
  assign move_active         = out_q.move_active;
  assign atk_start_pulse     = out_q.atk_start_pulse;
  assign move_start_pulse    = out_q.move_start_pulse;
  assign returned_to_neutral = out_q.returned_to_neutral;
  assign hitstun             = out_q.hitstun;
  assign blockstun           = out_q.blockstun;
  assign hitbox_active       = out_q.hitbox_active;
  assign move_dir            = out_q.move_dir;
  assign state               = state_q;

endmodule
